muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values are even and at least 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 SHALL have port src_a  input  WIDTH  multiplicand/dividend/MTHI-MTLO data.
REQ-007 SHALL have port src_b  input  WIDTH  multiplier/divisor.
REQ-008 SHALL have port flush  input  1  abort an in-flight operation.
REQ-009 SHALL have port busy  output  1  operation in flight; pipeline stalls on it.
REQ-010 SHALL have port done  output  1  one-cycle pulse; new HI/LO valid in the same cycle.
REQ-011 SHALL have port hi  output  WIDTH  HI register (MFHI source).
REQ-012 SHALL have port lo  output  WIDTH  LO register (MFLO source).

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; busy=1 in CALC and FIX only.
REQ-014 SHALL, in IDLE with start=1 and op in {000..011}, latch src_a/src_b/op and enter CALC on that edge.
REQ-015 SHALL iterate in CALC for exactly WIDTH cycles: radix-2 shift-add multiply, or restoring divide, one bit per cycle on magnitudes.
REQ-016 SHALL apply sign fix-up in FIX, write hi/lo on the edge leaving FIX and assert done=1 for exactly the following cycle.
REQ-017 SHALL give a total latency of WIDTH+2 cycles from the start edge to done high; done=1 for N=WIDTH+2 cycles after the start edge.
REQ-018 SHALL produce a multiply result of {hi,lo} = full 2*WIDTH-bit product.
REQ-019 SHALL produce a divide result of lo=quotient and hi=remainder; signed quotient is truncated toward zero and the remainder takes the sign of the dividend.
REQ-020 SHALL, on divisor zero, complete with normal latency and set lo=all ones, hi=src_a.
REQ-021 SHALL, in IDLE with start=1 and op=100/101, write hi/lo=src_a on that edge; busy and done are not asserted.
REQ-022 SHALL ignore start while busy=1; no queuing.
REQ-023 SHALL, on flush=1 in CALC or FIX, return to IDLE on that edge; hi/lo unchanged; done not asserted.
REQ-024 SHALL give flush priority when flush and start are both 1 in IDLE; start is ignored.
REQ-025 SHALL treat op 110/111 with start as a no-op; state and outputs unchanged.
REQ-026 SHALL accept a start in the same cycle that done=1, since the FSM is in IDLE.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=IDLE, hi=0, lo=0, busy=0 and done=0.
REQ-028 SHALL give rst priority over flush and start.
REQ-029 SHALL discard any in-flight operation on reset mid-operation, with no done pulse.

Configuration
REQ-030 SHALL, with MULDIV_SIGNED_EN defined, execute MULT/DIV as two's-complement signed operations per REQ-019.
REQ-031 SHALL, without MULDIV_SIGNED_EN, execute MULT/DIV identically to MULTU/DIVU and remove the sign fix-up logic; latency is unchanged.

Verification (WIDTH=32, MULDIV_SIGNED_EN defined unless noted)
REQ-032 SHALL cover: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 cycles after the start edge, hi=0xFFFFFFFE, lo=0x00000001, busy high 34 cycles.
REQ-033 SHALL cover: MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; without the macro -> hi=0x00000006 lo=0xFFFFFFEB.
REQ-034 SHALL cover: DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> lo=0xFFFFFFFF hi=0x00000007.
REQ-035 SHALL cover: MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated after one edge each, done never 1.
REQ-036 SHALL cover: preload hi=lo=0xA5A5A5A5, start DIVU, flush at cycle 10 -> busy=0 next cycle, no done, hi/lo still 0xA5A5A5A5; MTHI issued while busy -> ignored.
REQ-037 SHALL cover: rst asserted at cycle 5 of a MULT -> hi=lo=0, busy=0, done=0 next cycle, no later done.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit (MULTU/MULT/DIVU/DIV,
// MTHI/MTLO). One bit per cycle; busy stalls the pipeline while in flight.
// Compile-time option: define MULDIV_SIGNED_EN to give MULT/DIV
// two's-complement semantics; without it they behave as MULTU/DIVU.
// Timeline from the start edge: one setup cycle (operand magnitudes),
// WIDTH iteration cycles, one fix-up cycle, then done for one cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               accept, arith_go, fix_wr, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Flush beats start in IDLE; ops 110/111 fall through as no-ops.
  assign accept   = (state == S_IDLE) && start && !flush;
  assign arith_go = accept && !op[2];
  assign fix_wr   = (state == S_FIX) && !flush;
  assign busy     = (state != S_IDLE);
  assign div_zero = (b_q == '0);

`ifdef MULDIV_SIGNED_EN
  logic sgn_q;
  logic a_neg, b_neg;
  assign a_neg    = sgn_q & a_q[WIDTH-1];
  assign b_neg    = sgn_q & b_q[WIDTH-1];
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;
  // Product and quotient negative when signs differ; remainder follows dividend.
  assign prod_res = (a_neg ^ b_neg) ? -acc : acc;
  assign quo_res  = (a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_res  = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`else
  assign a_mag    = a_q;
  assign b_mag    = b_q;
  assign prod_res = acc;
  assign quo_res  = acc[WIDTH-1:0];
  assign rem_res  = acc[2*WIDTH-1:WIDTH];
`endif

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring-divide step: acc = {partial remainder, dividend/quotient bits}.
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign res_hi = is_div ? (div_zero ? a_q : rem_res) : prod_res[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? (div_zero ? '1  : quo_res) : prod_res[WIDTH-1:0];

  // State register and iteration counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CALC) cnt <= cnt + CW'(1);
      else                 cnt <= '0;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through this block leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE: if (arith_go) state_nxt = S_CALC;
      S_CALC: begin
        if (flush)                    state_nxt = S_IDLE;
        else if (cnt == CW'(WIDTH))   state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, magnitude setup (cnt==0), then one iteration per cycle.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; they are always loaded before
    // use and are qualified by the reset FSM.
    if (arith_go) begin
      a_q    <= src_a;
      b_q    <= src_b;
      is_div <= op[1];
`ifdef MULDIV_SIGNED_EN
      sgn_q  <= op[0];
`endif
    end else if (state == S_CALC) begin
      if (cnt == '0) begin
        opnd <= is_div ? b_mag : a_mag;
        acc  <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
      end else begin
        acc  <= is_div ? div_next : mul_next;
      end
    end
  end

  // Architectural HI/LO: direct moves from IDLE, results on leaving FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_wr) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (accept && op[2] && !op[1]) begin
      if (op[0]) lo <= src_a;
      else       hi <= src_a;
    end
  end

  // Completion pulse for the cycle after the result write.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= fix_wr;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed table, corner
// sequences (MTHI/MTLO, flush, reset, no-op) and randomized ops checked
// against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.hi = eh; v.lo = el; v.name = nm;
    vecs.push_back(v);
  endtask

  // Reference: {hi,lo} from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    bit     sg;
    longint sa, sb, q, r, p;
    logic [63:0] ua, ub;
    sg = SIGNED && o[0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (!o[1]) begin
      if (sg) begin
        p = sa * sb;
        return p;
      end
      return ua * ub;
    end
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Issue one arithmetic op; return edges from start edge to done and busy cycles.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int bc);
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick;
    start = 1'b0;
    lat = -1;
    bc  = 0;
    for (int k = 0; k <= 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bc++;
      tick;
    end
  endtask

  function automatic int count_done_dummy(input int x);
    return x;
  endfunction

  initial begin
    int lat, bc, nd;
    logic [63:0] m;
    logic [2:0]  ro;
    logic [W-1:0] ra, rb;

    add_vec(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    add_vec(3'b001, 32'hFFFF_FFFD, 32'd7,
            SIGNED ? 32'hFFFF_FFFF : 32'h0000_0006, 32'hFFFF_FFEB, "mult_neg3x7");
    add_vec(3'b011, 32'hFFFF_FFF9, 32'd2,
            SIGNED ? 32'hFFFF_FFFF : 32'h0000_0001,
            SIGNED ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, "div_neg7_2");
    add_vec(3'b010, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, "divu_by0");
    add_vec(3'b010, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
    add_vec(3'b011, 32'd7, 32'hFFFF_FFFE,
            SIGNED ? 32'd1 : 32'd7, SIGNED ? 32'hFFFF_FFFD : 32'd0, "div_7_neg2");
    add_vec(3'b011, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0_neg");
    add_vec(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin");
    add_vec(3'b000, 32'd0, 32'h1234_5678, 32'd0, 32'd0, "multu_zero");

    // Reset state.
    repeat (3) tick;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick;

    // Directed table; each op starts in the done cycle of the previous one.
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check({vecs[i].name, "_lat"}, lat, LAT);
      check({vecs[i].name, "_busy"}, bc, LAT);
      check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
    end
    tick;
    check("done_one_cycle", done, 0);

    // MTHI then MTLO on consecutive cycles.
    start = 1'b1; op = 3'b100; src_a = 32'h1234_5678;
    tick;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_done", done, 0);
    check("mthi_busy", busy, 0);
    op = 3'b101; src_a = 32'h9ABC_DEF0;
    tick;
    start = 1'b0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", hi, 32'h1234_5678);
    check("mtlo_done", done, 0);

    // Preload, DIVU, MTHI while busy, flush at cycle 10.
    start = 1'b1; op = 3'b100; src_a = 32'hA5A5_A5A5;
    tick;
    op = 3'b101;
    tick;
    op = 3'b010; src_a = 32'd1000; src_b = 32'd7;
    tick;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        start = 1'b1; op = 3'b100; src_a = 32'hDEAD_BEEF;
      end
      tick;
      start = 1'b0;
    end
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_hi", hi, 32'hA5A5_A5A5);
    check("flush_lo", lo, 32'hA5A5_A5A5);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) nd++;
      tick;
    end
    check("flush_no_late_done", nd, 0);

    // Flush beats start in IDLE.
    start = 1'b1; flush = 1'b1; op = 3'b100; src_a = 32'h1;
    tick;
    check("flush_start_mthi", hi, 32'hA5A5_A5A5);
    op = 3'b000;
    tick;
    check("flush_start_mul", busy, 0);
    flush = 1'b0;

    // No-op codes.
    op = 3'b110; src_a = 32'h5555_5555; src_b = 32'd3;
    tick;
    check("noop6_busy", busy, 0);
    op = 3'b111;
    tick;
    start = 1'b0;
    check("noop7_busy", busy, 0);
    check("noop_done", done, 0);
    check("noop_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

    // Reset at cycle 5 of a MULT.
    start = 1'b1; op = 3'b001; src_a = 32'd9; src_b = 32'd9;
    tick;
    start = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    nd = count_done_dummy(0);
    for (int c = 0; c < 40; c++) begin
      if (done) nd++;
      tick;
    end
    check("midrst_no_done", nd, 0);

    // Randomized arithmetic ops against the model.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: ra = W'($urandom_range(0, 100));
        3: rb = -W'($urandom_range(1, 9));
        default: ;
      endcase
      m = model(ro, ra, rb);
      do_op(ro, ra, rb, lat, bc);
      check($sformatf("rnd%0d_lat", i), lat, LAT);
      check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), {hi, lo}, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
